// File: rtl/ifetch_unit.sv
// Instruction fetch front end: sequential PC generation, in-order requests to a
// variable-latency instruction memory, and a prefetch queue feeding decode.
module ifetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_X = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] inflight;
    logic [CW-1:0] discard;
    logic [CW-1:0] count;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    logic [31:0]   q_pc   [DEPTH];
    logic [31:0]   q_inst [DEPTH];

    logic [CW:0]   occupancy;
    logic          fire;
    logic          push;
    logic          drop;
    logic          pop;
    logic [CW-1:0] inflight_next;
    logic [31:0]   target_pc;
    logic          unused_low_bits;

    assign target_pc       = {redirect_pc[31:2], 2'b00};
    assign unused_low_bits = ^redirect_pc[1:0];

    // Live work = queued words plus requests whose answers will be kept.
    assign occupancy = {1'b0, count} + {1'b0, inflight} - {1'b0, discard};

    assign imem_req_valid = !rst && !redirect
                         && (occupancy < DEPTH_X)
                         && ({1'b0, inflight} < DEPTH_X);
    assign imem_req_addr  = fetch_pc;
    assign fire           = imem_req_valid && imem_req_ready;

    assign drop = imem_resp_valid && (discard != '0);
    assign push = imem_resp_valid && !redirect && (discard == '0);

    assign inst_valid = !rst && (count != '0);
    assign inst_data  = rst ? 32'h0 : q_inst[rd_ptr];
    assign inst_pc    = rst ? 32'h0 : q_pc[rd_ptr];
    assign pop        = inst_valid && inst_ready && !redirect;

    assign inflight_next = inflight + CW'(fire) - CW'(imem_resp_valid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            inflight <= '0;
            discard  <= '0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            inflight <= inflight_next;
            if (redirect) begin
                // Every request still outstanding after this cycle is stale.
                fetch_pc <= target_pc;
                resp_pc  <= target_pc;
                discard  <= inflight_next;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (drop) begin
                    discard <= discard - CW'(1);
                end
                if (push) begin
                    resp_pc <= resp_pc + 32'd4;
                    wr_ptr  <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // Queue storage carries data only, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]   <= resp_pc;
            q_inst[wr_ptr] <= imem_resp_data;
        end
    end

endmodule
